fsm_pulse_gen: RTL and testbench
================================

Name: fsm_pulse_gen

Overview:
- Parametrised Moore-type trigger-to-pulse generator, the successor to the lab fixed-shape single-pulse FSM.
- Samples level input X_IN. On a trigger it drives Y_OUT high for exactly HIGH_CYCLES clocks, then enforces a GAP_CYCLES low guard interval.
- Adds an optional retrigger-extend mode, a busy flag, a done strobe and a wrapping pulse counter.
- Used as a building block for stimulus/indicator pulse shaping in the lab designs.

Parameters:
- HIGH_CYCLES, 3: width of the output pulse in clocks; legal range 1..2^TIMER_W.
- GAP_CYCLES, 1: low guard interval after the pulse in clocks; legal range 0..2^TIMER_W.
- TIMER_W, 8: width of the internal down-counter.
- CNT_W, 8: width of PULSE_CNT.
- RETRIG_EXT, 0: 1 = X_IN high during the pulse restarts the high interval; 0 = X_IN ignored during the pulse.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- nRST  input  1  reset, asynchronous, active-low.
- X_IN  input  1  trigger level, synchronous to CLK.
- CLR  input  1  synchronous clear of PULSE_CNT only.
- Y_OUT  output  1  shaped pulse, registered.
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  one-cycle strobe, high in the first cycle Y_OUT is low after a pulse.
- PULSE_CNT  output  CNT_W  number of pulses started, modulo 2^CNT_W.

Behaviour:
- Reset: nRST low forces, immediately and independently of CLK:
  - state = IDLE, timer = 0, Y_OUT = 0, BUSY = 0, DONE = 0, PULSE_CNT = 0.
  - Reset mid-pulse truncates the pulse with no DONE.
- States: IDLE(0), HIGH(1), GAP(2), CHECK(3), 2-bit encoding. Y_OUT and BUSY are pure decodes of the registered state (Moore). DONE is its own register.
- IDLE:
  - X_IN=1 at posedge -> HIGH; timer <= HIGH_CYCLES-1; PULSE_CNT += 1.
  - Otherwise stay in IDLE.
- HIGH (Y_OUT=1):
  - RETRIG_EXT=1 and X_IN=1: timer <= HIGH_CYCLES-1 and stay in HIGH. This takes priority over expiry.
  - Else if timer==0: exit with DONE <= 1. Exit goes to GAP with timer <= GAP_CYCLES-1 when GAP_CYCLES>0, or directly to CHECK when GAP_CYCLES==0.
  - Else timer <= timer-1.
- GAP (Y_OUT=0):
  - timer==0 -> CHECK.
  - Else timer decrements.
  - X_IN is ignored.
- CHECK (Y_OUT=0, one cycle):
  - X_IN=1 -> HIGH; timer <= HIGH_CYCLES-1; PULSE_CNT += 1.
  - Otherwise -> IDLE.
- Timing:
  - Latency: X_IN sampled high at edge k puts Y_OUT high from edge k until edge k+HIGH_CYCLES (exactly HIGH_CYCLES cycles, no extension).
  - Minimum trigger-to-trigger period with X_IN held high: HIGH_CYCLES + GAP_CYCLES + 1 cycles.
- DONE: high for exactly one cycle, the cycle after the HIGH exit edge; low in all other cycles.
- PULSE_CNT:
  - Increments only on IDLE->HIGH and CHECK->HIGH transitions. Retrigger-extends do not count.
  - Wraps from 2^CNT_W-1 to 0.
  - CLR=1 sets it to 0 and wins over a simultaneous increment.
  - CLR does not affect the state machine.
- Unused or illegal state encodings are unreachable; the default branch returns to IDLE with Y_OUT=0.
- No combinational path from X_IN to any output.

Test Plan:
- Defaults; release nRST; single 1-cycle X_IN=1 at edge 10 -> Y_OUT high for cycles 10..12 (3 cycles); DONE high cycle 13 only; BUSY high cycles 10..14; PULSE_CNT=1.
- Defaults; X_IN held high for 20 cycles -> pulses of 3 high / 2 low, period 5; PULSE_CNT=4 after 20 cycles; DONE once per pulse.
- RETRIG_EXT=1, HIGH_CYCLES=4; X_IN high at edges 0 and 2 -> Y_OUT high for 6 cycles (0..5); PULSE_CNT=1; one DONE, at cycle 6.
- GAP_CYCLES=0, HIGH_CYCLES=1; X_IN held high -> Y_OUT toggles 1,0,1,0 (period 2); PULSE_CNT increments every 2 cycles.
- CNT_W=2; 5 isolated triggers -> PULSE_CNT sequence 1,2,3,0,1. CLR asserted on the same edge as a trigger -> PULSE_CNT=0.
- nRST asserted asynchronously between edges mid-HIGH -> Y_OUT, BUSY, DONE and PULSE_CNT all 0 immediately; no DONE after release; next trigger produces a full HIGH_CYCLES pulse.

Source files
------------

// File: rtl/fsm_pulse_gen.sv
// Trigger-to-pulse shaper: a sampled X_IN level starts a HIGH_CYCLES-wide pulse on
// Y_OUT, followed by a GAP_CYCLES low guard interval and a one-cycle re-arm check.
// Latency: Y_OUT rises on the same edge that samples X_IN high; no backpressure (free-running).
//
// Ports:
//   CLK        system clock, all state changes on posedge
//   nRST       asynchronous active-low reset
//   X_IN       trigger level, synchronous to CLK
//   CLR        synchronous clear of PULSE_CNT only (wins over an increment)
//   Y_OUT      shaped pulse, decoded from registered state
//   BUSY       high whenever the machine is not idle
//   DONE       one-cycle strobe in the first low cycle after a pulse
//   PULSE_CNT  pulses started, modulo 2^CNT_W
module fsm_pulse_gen #(
    parameter int HIGH_CYCLES = 3,
    parameter int GAP_CYCLES  = 1,
    parameter int TIMER_W     = 8,
    parameter int CNT_W       = 8,
    parameter int RETRIG_EXT  = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             X_IN,
    input  logic             CLR,
    output logic             Y_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] PULSE_CNT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    // Timers count down to zero, so the reload value is the interval minus one.
    localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? TIMER_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;

    logic [1:0]         w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_done_nxt;
    logic               w_start;     // a new pulse begins on this edge

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (X_IN) begin
                    w_state_nxt = S_HIGH;
                    w_timer_nxt = HIGH_LOAD;
                    w_start     = 1'b1;
                end
            end
            S_HIGH: begin
                // Retrigger restarts the high interval and beats expiry on the same edge.
                if ((RETRIG_EXT != 0) && X_IN) begin
                    w_timer_nxt = HIGH_LOAD;
                end else if (r_timer == '0) begin
                    w_done_nxt = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = S_GAP;
                        w_timer_nxt = GAP_LOAD;
                    end else begin
                        w_state_nxt = S_CHECK;
                        w_timer_nxt = '0;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_CHECK: begin
                if (X_IN) begin
                    w_state_nxt = S_HIGH;
                    w_timer_nxt = HIGH_LOAD;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Counter only tracks pulse starts; extends and the FSM itself ignore CLR.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign Y_OUT     = (r_state == S_HIGH);
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = r_done;
    assign PULSE_CNT = r_cnt;

endmodule

// File: tb/tb_fsm_pulse_gen.sv
// Bench for fsm_pulse_gen: four parameterisations driven from shared stimulus,
// checked every cycle against a timestamp model plus directed literal expectations.
// No backpressure; stimulus is a fixed number of clock ticks, so the run always ends.
module tb_fsm_pulse_gen;

    localparam int N = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    logic X_IN = 1'b0;
    logic CLR  = 1'b0;

    logic [N-1:0] y_o;
    logic [N-1:0] busy_o;
    logic [N-1:0] done_o;
    logic [7:0]   pc0, pc1, pc2;
    logic [1:0]   pc3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    // u0: defaults; u1: retrigger-extend H=4; u2: H=1 G=0; u3: 2-bit counter
    fsm_pulse_gen #(.HIGH_CYCLES(3), .GAP_CYCLES(1), .TIMER_W(8), .CNT_W(8), .RETRIG_EXT(0)) u0 (
        .CLK(CLK), .nRST(nRST), .X_IN(X_IN), .CLR(CLR),
        .Y_OUT(y_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]), .PULSE_CNT(pc0));
    fsm_pulse_gen #(.HIGH_CYCLES(4), .GAP_CYCLES(1), .TIMER_W(8), .CNT_W(8), .RETRIG_EXT(1)) u1 (
        .CLK(CLK), .nRST(nRST), .X_IN(X_IN), .CLR(CLR),
        .Y_OUT(y_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]), .PULSE_CNT(pc1));
    fsm_pulse_gen #(.HIGH_CYCLES(1), .GAP_CYCLES(0), .TIMER_W(8), .CNT_W(8), .RETRIG_EXT(0)) u2 (
        .CLK(CLK), .nRST(nRST), .X_IN(X_IN), .CLR(CLR),
        .Y_OUT(y_o[2]), .BUSY(busy_o[2]), .DONE(done_o[2]), .PULSE_CNT(pc2));
    fsm_pulse_gen #(.HIGH_CYCLES(3), .GAP_CYCLES(1), .TIMER_W(8), .CNT_W(2), .RETRIG_EXT(0)) u3 (
        .CLK(CLK), .nRST(nRST), .X_IN(X_IN), .CLR(CLR),
        .Y_OUT(y_o[3]), .BUSY(busy_o[3]), .DONE(done_o[3]), .PULSE_CNT(pc3));

    function automatic int p_h(input int i);
        case (i) 1: return 4; 2: return 1; default: return 3; endcase
    endfunction
    function automatic int p_g(input int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int p_r(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int p_mod(input int i);
        return (i == 3) ? 4 : 256;
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0: return int'(pc0);
            1: return int'(pc1);
            2: return int'(pc2);
            default: return int'(pc3);
        endcase
    endfunction

    // Timestamp model: edges are numbered from reset release. A pulse started at
    // edge s occupies Y for edges s..exit-1 (exit = s+H, pushed out by retriggers),
    // DONE fires after edge exit, and the next start is allowed from edge exit+G+1.
    int lk;
    int exit_e [N];
    int ready_e[N];
    int mcnt   [N];
    int n_exit [N];
    int n_ready[N];
    int n_cnt  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            n_exit[i]  = exit_e[i];
            n_ready[i] = ready_e[i];
            n_cnt[i]   = mcnt[i];
            if ((p_r(i) != 0) && X_IN && (lk + 1 <= exit_e[i])) begin
                n_exit[i]  = lk + 1 + p_h(i);
                n_ready[i] = n_exit[i] + p_g(i) + 1;
            end else if (X_IN && (lk + 1 >= ready_e[i])) begin
                n_exit[i]  = lk + 1 + p_h(i);
                n_ready[i] = n_exit[i] + p_g(i) + 1;
                n_cnt[i]   = (mcnt[i] + 1) % p_mod(i);
            end
            if (CLR) n_cnt[i] = 0;
        end
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lk <= -1;
            for (int i = 0; i < N; i++) begin
                exit_e[i]  <= -100;
                ready_e[i] <= -100;
                mcnt[i]    <= 0;
            end
        end else begin
            lk <= lk + 1;
            for (int i = 0; i < N; i++) begin
                exit_e[i]  <= n_exit[i];
                ready_e[i] <= n_ready[i];
                mcnt[i]    <= n_cnt[i];
            end
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk("y",    i, int'(y_o[i]),    int'(lk < exit_e[i]));
                chk("busy", i, int'(busy_o[i]), int'(lk < ready_e[i]));
                chk("done", i, int'(done_o[i]), int'(lk == exit_e[i]));
                chk("cnt",  i, dut_cnt(i),      mcnt[i]);
            end
        end
    end

    task automatic tick(input logic xv, input logic cv);
        X_IN = xv;
        CLR  = cv;
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset();
        #2 nRST = 1'b0;
        #1;
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        logic [5:0] py6, pd6, pb6;
        logic [7:0] py8, pd8;
        int nd;

        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_y",    i, int'(y_o[i]),    0);
            chk("rst_busy", i, int'(busy_o[i]), 0);
            chk("rst_done", i, int'(done_o[i]), 0);
            chk("rst_cnt",  i, dut_cnt(i),      0);
        end
        nRST   = 1'b1;
        chk_en = 1'b1;
        repeat (4) tick(1'b0, 1'b0);

        // single one-cycle trigger on the default shape
        py6 = 6'b000111; pd6 = 6'b001000; pb6 = 6'b011111;
        for (int j = 0; j < 6; j++) begin
            tick(j == 0, 1'b0);
            chk("t1_y",    0, int'(y_o[0]),    int'(py6[j]));
            chk("t1_done", 0, int'(done_o[0]), int'(pd6[j]));
            chk("t1_busy", 0, int'(busy_o[0]), int'(pb6[j]));
        end
        chk("t1_cnt", 0, dut_cnt(0), 1);
        repeat (4) tick(1'b0, 1'b0);

        // trigger held high for 20 cycles
        nd = 0;
        for (int j = 0; j < 20; j++) begin
            tick(1'b1, 1'b0);
            if (done_o[0]) nd++;
            chk("t2_y_toggle", 2, int'(y_o[2]), int'(j % 2 == 0));
        end
        chk("t2_cnt",   0, dut_cnt(0), 5);
        chk("t2_ndone", 0, nd, 4);
        chk("t2_cnt",   2, dut_cnt(2), 11);
        repeat (10) tick(1'b0, 1'b0);

        // retrigger extend: triggers two edges apart stretch the pulse to 6
        py8 = 8'b00111111; pd8 = 8'b01000000;
        for (int j = 0; j < 8; j++) begin
            tick((j == 0) || (j == 2), 1'b0);
            chk("t3_y",    1, int'(y_o[1]),    int'(py8[j]));
            chk("t3_done", 1, int'(done_o[1]), int'(pd8[j]));
        end
        chk("t3_cnt", 1, dut_cnt(1), 3);

        // counter wrap on the 2-bit instance, then CLR racing a trigger
        tick(1'b0, 1'b1);
        chk("t5_clr", 3, dut_cnt(3), 0);
        chk("t5_clr", 0, dut_cnt(0), 0);
        for (int n = 0; n < 5; n++) begin
            tick(1'b1, 1'b0);
            chk("t5_wrap", 3, dut_cnt(3), (n + 1) % 4);
            repeat (7) tick(1'b0, 1'b0);
        end
        tick(1'b1, 1'b1);
        chk("t5_clr_win", 3, dut_cnt(3), 0);
        chk("t5_clr_win", 0, dut_cnt(0), 0);
        chk("t5_fsm_run", 3, int'(y_o[3]), 1);
        repeat (8) tick(1'b0, 1'b0);

        // asynchronous reset in the middle of a pulse
        tick(1'b1, 1'b0);
        chk("t6_pre_cnt", 0, dut_cnt(0), 1);
        chk("t6_pre_y",   0, int'(y_o[0]), 1);
        X_IN = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("t6_y",    0, int'(y_o[0]),    0);
        chk("t6_busy", 0, int'(busy_o[0]), 0);
        chk("t6_done", 0, int'(done_o[0]), 0);
        chk("t6_cnt",  0, dut_cnt(0),      0);
        chk("t6_y",    1, int'(y_o[1]),    0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        nd = 0;
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, 1'b0);
            if (done_o[0]) nd++;
        end
        chk("t6_no_done", 0, nd, 0);
        for (int j = 0; j < 6; j++) begin
            tick(j == 0, 1'b0);
            chk("t6_full_y", 0, int'(y_o[0]), int'(py6[j]));
        end

        // randomized traffic with occasional clears and asynchronous resets
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                tick($urandom_range(0, 99) < ((j / 200) % 2 == 0 ? 30 : 75),
                     $urandom_range(0, 99) < 4);
            end
        end
        repeat (3) tick(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
